lsu_unit: RTL

Load/store unit between the multicycle control unit and the data cache. It accepts one memory request per instruction during the MEMORY state and checks alignment. It converts byte/half/word accesses into word-aligned dcache transactions with byte strobes, then returns sign- or zero-extended load data (or a store acknowledgement) to the control unit for WRITEBACK.

---
 rtl/lsu_unit_pkg.sv | 24 ++
 rtl/lsu_unit_if.sv | 50 +++++
 rtl/lsu_unit_align.sv | 73 +++++++
 rtl/lsu_unit.sv | 129 ++++++++++++
 4 files changed

// File: rtl/lsu_unit_pkg.sv
// Shared types for the load/store unit.
//   mem_size_t  : access width carried with each memory request
//   lsu_state_t : LSU control FSM states
//   STRB_W      : number of byte lanes in a data word
package lsu_unit_pkg;

  localparam int unsigned STRB_W = 4;

  // 2'b11 is not a legal access size; the LSU reports it as misaligned.
  typedef enum logic [1:0] {
    MEM_SIZE_B    = 2'b00,
    MEM_SIZE_H    = 2'b01,
    MEM_SIZE_W    = 2'b10,
    MEM_SIZE_RSVD = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    DC_REQ,
    DC_WAIT,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_unit_if.sv
// Bus bundle between the control unit, the LSU and the data cache.
//   req_*  / resp_* : control-unit request and response
//   dc_*            : data-cache request, write data, response
// Modports:
//   slave  : the LSU side (accepts requests, drives the dcache)
//   master : the environment side (control unit + dcache)
interface lsu_unit_if
  import lsu_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  mem_size_t             req_size;
  logic                  req_sign;

  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  logic                  dc_req_valid;
  logic                  dc_req_ready;
  logic                  dc_we;
  logic [DATA_WIDTH-1:0] dc_addr;
  logic [DATA_WIDTH-1:0] dc_wdata;
  logic [STRB_W-1:0]     dc_wstrb;
  logic                  dc_resp_valid;
  logic [DATA_WIDTH-1:0] dc_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_sign,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output dc_req_valid, dc_we, dc_addr, dc_wdata, dc_wstrb,
    input  dc_req_ready, dc_resp_valid, dc_rdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_sign,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  dc_req_valid, dc_we, dc_addr, dc_wdata, dc_wstrb,
    output dc_req_ready, dc_resp_valid, dc_rdata
  );

endinterface

// File: rtl/lsu_unit_align.sv
// lsu_align: purely combinational datapath helpers for the LSU.
//   chk_addr/chk_size -> misaligned : alignment check of an incoming request
//   addr/size/wdata   -> lane_wdata, lane_wstrb : store lane replication
//   addr/size/sign/rdata -> load_data : load lane extraction + extension
// Only a 32-bit data path (four byte lanes) is supported.
module lsu_align
  import lsu_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [1:0]            chk_addr,
  input  mem_size_t             chk_size,
  output logic                  misaligned,

  input  logic [1:0]            addr,
  input  mem_size_t             size,
  input  logic                  sign,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] lane_wdata,
  output logic [STRB_W-1:0]     lane_wstrb,
  output logic [DATA_WIDTH-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    misaligned = 1'b1;
    case (chk_size)
      MEM_SIZE_B: misaligned = 1'b0;
      MEM_SIZE_H: misaligned = chk_addr[0];
      MEM_SIZE_W: misaligned = |chk_addr;
      default:    misaligned = 1'b1;
    endcase
  end

  always_comb begin
    lane_wdata = '0;
    lane_wstrb = '0;
    case (size)
      MEM_SIZE_B: begin
        lane_wdata = {4{wdata[7:0]}};
        lane_wstrb = 4'b0001 << addr;
      end
      MEM_SIZE_H: begin
        lane_wdata = {2{wdata[15:0]}};
        lane_wstrb = 4'b0011 << addr;
      end
      MEM_SIZE_W: begin
        lane_wdata = wdata;
        lane_wstrb = 4'b1111;
      end
      default: begin
        lane_wdata = '0;
        lane_wstrb = '0;
      end
    endcase
  end

  always_comb begin
    byte_sel  = rdata[{addr, 3'b000} +: 8];
    half_sel  = addr[1] ? rdata[31:16] : rdata[15:0];
    load_data = '0;
    case (size)
      MEM_SIZE_B: load_data = sign ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
      MEM_SIZE_H: load_data = sign ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
      MEM_SIZE_W: load_data = rdata;
      default:    load_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_unit.sv
// lsu_unit: load/store unit between the multicycle control unit and the dcache.
// Accepts one request in IDLE, rejects misaligned/undefined-size accesses
// without touching the dcache, otherwise issues one word-aligned dcache
// transaction with byte strobes and returns extended load data (0 for
// stores/errors) as a one-cycle resp_valid pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : lsu_unit_if.slave (req_*, resp_*, dc_* signals)
module lsu_unit
  import lsu_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  lsu_unit_if.slave bus
);

  lsu_state_t state_q, state_d;

  // Request fields latched at accept; all dc_* outputs decode from these.
  logic                  we_q;
  logic                  sign_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  mem_size_t             size_q;

  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic                  req_misaligned;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [STRB_W-1:0]     lane_wstrb;
  logic [DATA_WIDTH-1:0] load_data;

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .chk_addr   (bus.req_addr[1:0]),
    .chk_size   (bus.req_size),
    .misaligned (req_misaligned),
    .addr       (addr_q[1:0]),
    .size       (size_q),
    .sign       (sign_q),
    .wdata      (wdata_q),
    .rdata      (bus.dc_rdata),
    .lane_wdata (lane_wdata),
    .lane_wstrb (lane_wstrb),
    .load_data  (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    bus.req_ready    = 1'b0;
    bus.resp_valid   = 1'b0;
    bus.dc_req_valid = 1'b0;
    bus.dc_we        = 1'b0;
    bus.dc_addr      = '0;
    bus.dc_wdata     = '0;
    bus.dc_wstrb     = '0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = req_misaligned ? RESP : DC_REQ;
      end
      DC_REQ: begin
        bus.dc_req_valid = 1'b1;
        bus.dc_we        = we_q;
        bus.dc_addr      = {addr_q[DATA_WIDTH-1:2], 2'b00};
        bus.dc_wdata     = we_q ? lane_wdata : '0;
        bus.dc_wstrb     = we_q ? lane_wstrb : '0;
        if (bus.dc_req_ready) state_d = DC_WAIT;
      end
      DC_WAIT: begin
        if (bus.dc_resp_valid) state_d = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response register is only non-zero during RESP, so resp_rdata/resp_err
  // read as zero whenever resp_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= MEM_SIZE_B;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            sign_q  <= bus.req_sign;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            size_q  <= bus.req_size;
            rdata_q <= '0;
            err_q   <= req_misaligned;
          end
        end
        DC_WAIT: begin
          if (bus.dc_resp_valid) begin
            rdata_q <= we_q ? '0 : load_data;
            err_q   <= 1'b0;
          end
        end
        RESP: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule
